// File: rtl/wb_pkg.sv
// Shared widths, requester indices and the writeback bus record for the
// execute-unit writeback arbiter.
package wb_pkg;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ROBID_W = 7;
  localparam int RD_W    = 6;
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam int SCALU0 = 0;
  localparam int SCALU1 = 1;
  localparam int MCALU0 = 2;
  localparam int MCALU1 = 3;

  typedef struct packed {
    logic               valid;
    logic               error;
    logic [ROBID_W-1:0] robid;
    logic [RD_W-1:0]    rd;
    logic [DATA_W-1:0]  result;
  } wb_bus_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: rotate requests so ptr is bit 0, pick the
// lowest set bit, rotate the pick back. flush suppresses every grant.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             flush,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);
  logic [N-1:0] req_rot;
  logic [N-1:0] pri_rot;
  logic [N-1:0] gnt_raw;

  always_comb begin
    req_rot = N'({req, req} >> ptr);
    pri_rot = req_rot & (~req_rot + N'(1));
    gnt_raw = N'(({pri_rot, pri_rot} << ptr) >> N);
    grant   = flush ? '0 : gnt_raw;
    any     = |grant;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) gnt_idx = PTR_W'(i);
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback bus scheduler: one result buffer per execute unit, round-robin
// grant of one buffered result per cycle onto the registered wb bus.
module wb_arbiter
  import wb_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_error,
  input  logic [NUM_REQ*ROBID_W-1:0] req_robid,
  input  logic [NUM_REQ*RD_W-1:0]    req_rd,
  input  logic [NUM_REQ*DATA_W-1:0]  req_result,
  output logic [NUM_REQ-1:0]         req_stall,
  output logic                       wb_valid,
  output logic                       wb_error,
  output logic [ROBID_W-1:0]         wb_robid,
  output logic [RD_W-1:0]            wb_rd,
  output logic [DATA_W-1:0]          wb_result,
  input  logic                       rob_flush
);
  logic [NUM_REQ-1:0] buf_valid;
  logic [NUM_REQ-1:0] buf_error;
  logic [ROBID_W-1:0] buf_robid  [NUM_REQ];
  logic [RD_W-1:0]    buf_rd     [NUM_REQ];
  logic [DATA_W-1:0]  buf_result [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  wb_bus_t            wb_p1;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req     (buf_valid),
    .ptr     (rr_ptr),
    .flush   (rob_flush),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // A granted buffer is free this cycle, so its unit may refill it immediately.
  assign req_stall = buf_valid & ~grant;
  assign accept    = req_valid & ~req_stall & {NUM_REQ{~rob_flush}};

  // p0: result buffers and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
    end else begin
      if (rob_flush) buf_valid <= '0;
      else           buf_valid <= accept | (buf_valid & ~grant);
      if (gnt_any)
        rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        buf_error[i]  <= req_error[i];
        buf_robid[i]  <= req_robid[i*ROBID_W +: ROBID_W];
        buf_rd[i]     <= req_rd[i*RD_W +: RD_W];
        buf_result[i] <= req_result[i*DATA_W +: DATA_W];
      end
    end
  end

  // p1: writeback register; payload holds when nothing is granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_p1 <= '0;
    end else if (gnt_any) begin
      wb_p1 <= '{valid:  1'b1,
                 error:  buf_error[gnt_idx],
                 robid:  buf_robid[gnt_idx],
                 rd:     buf_rd[gnt_idx],
                 result: buf_result[gnt_idx]};
    end else begin
      wb_p1.valid <= 1'b0;
    end
  end

  assign wb_valid  = wb_p1.valid;
  assign wb_error  = wb_p1.error;
  assign wb_robid  = wb_p1.robid;
  assign wb_rd     = wb_p1.rd;
  assign wb_result = wb_p1.result;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a queue-free behavioural model checked on
// every falling edge, plus literal expectations for each scenario.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ-1:0]         req_error = '0;
  logic [NUM_REQ*ROBID_W-1:0] req_robid = '0;
  logic [NUM_REQ*RD_W-1:0]    req_rd = '0;
  logic [NUM_REQ*DATA_W-1:0]  req_result = '0;
  logic [NUM_REQ-1:0]         req_stall;
  logic                       wb_valid, wb_error;
  logic [ROBID_W-1:0]         wb_robid;
  logic [RD_W-1:0]            wb_rd;
  logic [DATA_W-1:0]          wb_result;
  logic                       rob_flush = 1'b0;

  wb_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_error(req_error),
    .req_robid(req_robid), .req_rd(req_rd), .req_result(req_result),
    .req_stall(req_stall), .wb_valid(wb_valid), .wb_error(wb_error),
    .wb_robid(wb_robid), .wb_rd(wb_rd), .wb_result(wb_result),
    .rob_flush(rob_flush)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: per-unit slot contents and a pointer, winner found by scanning.
  bit                 m_full   [NUM_REQ];
  bit                 m_err    [NUM_REQ];
  logic [ROBID_W-1:0] m_robid  [NUM_REQ];
  logic [RD_W-1:0]    m_rd     [NUM_REQ];
  logic [DATA_W-1:0]  m_result [NUM_REQ];
  int                 m_ptr;
  bit                 e_valid, e_error;
  logic [ROBID_W-1:0] e_robid;
  logic [RD_W-1:0]    e_rd;
  logic [DATA_W-1:0]  e_result;

  function automatic int m_winner();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (m_full[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    int w;
    bit busy [NUM_REQ];
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) m_full[i] <= 1'b0;
      m_ptr <= 0; e_valid <= 1'b0; e_error <= 1'b0;
      e_robid <= '0; e_rd <= '0; e_result <= '0;
    end else begin
      w = rob_flush ? -1 : m_winner();
      for (int i = 0; i < NUM_REQ; i++) busy[i] = m_full[i] && (i != w);
      if (rob_flush) begin
        for (int i = 0; i < NUM_REQ; i++) m_full[i] <= 1'b0;
        e_valid <= 1'b0;
      end else begin
        if (w >= 0) begin
          e_valid <= 1'b1; e_error <= m_err[w]; e_robid <= m_robid[w];
          e_rd <= m_rd[w]; e_result <= m_result[w];
          m_ptr <= (w + 1) % NUM_REQ;
          m_full[w] <= 1'b0;
        end else begin
          e_valid <= 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i] && !busy[i]) begin
            m_full[i]   <= 1'b1;
            m_err[i]    <= req_error[i];
            m_robid[i]  <= req_robid[i*ROBID_W +: ROBID_W];
            m_rd[i]     <= req_rd[i*RD_W +: RD_W];
            m_result[i] <= req_result[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int w;
    logic [NUM_REQ-1:0] exp_stall;
    if (rst) begin
      w = rob_flush ? -1 : m_winner();
      for (int i = 0; i < NUM_REQ; i++) exp_stall[i] = m_full[i] && (i != w);
      check("model_wb_valid", 64'(wb_valid), 64'(e_valid));
      check("model_wb_fields", {18'd0, wb_error, wb_robid, wb_rd, wb_result},
            {18'd0, e_error, e_robid, e_rd, e_result});
      check("model_req_stall", 64'(req_stall), 64'(exp_stall));
    end
  end

  task automatic edge_();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_error = '0;
  endtask

  task automatic set_req(input int i, input logic err, input logic [ROBID_W-1:0] robid,
                         input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] res);
    req_valid[i] = 1'b1;
    req_error[i] = err;
    req_robid[i*ROBID_W +: ROBID_W] = robid;
    req_rd[i*RD_W +: RD_W] = rd;
    req_result[i*DATA_W +: DATA_W] = res;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    edge_();
    rst = 1'b1;
    edge_();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [ROBID_W-1:0] exp_robid [5];
    exp_robid = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4};

    #2;
    check("reset_wb_valid", 64'(wb_valid), 64'd0);
    check("reset_stall", 64'(req_stall), 64'd0);
    check("reset_wb_result", 64'(wb_result), 64'd0);
    check("reset_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    edge_();
    rst = 1'b1;
    edge_();

    // Single request from mcalu0
    set_req(MCALU0, 1'b0, 7'h15, 6'h03, 32'hDEADBEEF);
    edge_();
    clr_req();
    check("single_c1_valid", 64'(wb_valid), 64'd0);
    check("single_c1_stall", 64'(req_stall), 64'd0);
    check("single_c1_buf", 64'(dut.buf_valid), 64'b0100);
    edge_();
    check("single_c2_valid", 64'(wb_valid), 64'd1);
    check("single_c2_robid", 64'(wb_robid), 64'h15);
    check("single_c2_rd", 64'(wb_rd), 64'h03);
    check("single_c2_result", 64'(wb_result), 64'hDEADBEEF);
    check("single_c2_stall", 64'(req_stall), 64'd0);
    edge_();
    check("single_c3_valid", 64'(wb_valid), 64'd0);
    check("single_c3_hold", 64'(wb_result), 64'hDEADBEEF);

    // Error and no-write tag pass through untouched
    set_req(SCALU1, 1'b1, 7'h11, 6'h20, 32'h12345678);
    edge_();
    clr_req();
    edge_();
    check("err_valid", 64'(wb_valid), 64'd1);
    check("err_flag", 64'(wb_error), 64'd1);
    check("err_rd", 64'(wb_rd), 64'h20);
    edge_();

    // Full contention from a fresh pointer
    pulse_reset();
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, 1'b0, ROBID_W'(k * 4 + i), RD_W'(i), DATA_W'(k * 256 + i));
      edge_();
      check("cont_stall", 64'(req_stall), 64'(4'hF & ~(4'b0001 << (k % 4))));
      if (k >= 1) begin
        check("cont_valid", 64'(wb_valid), 64'd1);
        check("cont_order", 64'(wb_rd), 64'((k - 1) % 4));
      end
      if (k >= 1 && k <= 5) check("cont_robid", 64'(wb_robid), 64'(exp_robid[k-1]));
    end
    clr_req();
    repeat (6) edge_();

    // Pointer at 2 with buffers 0 and 3 waiting
    pulse_reset();
    set_req(SCALU1, 1'b0, 7'h41, 6'd1, 32'h1);
    edge_();
    clr_req();
    set_req(SCALU0, 1'b0, 7'h40, 6'd0, 32'h0);
    set_req(MCALU1, 1'b0, 7'h43, 6'd3, 32'h3);
    edge_();
    clr_req();
    check("ptr_at_2", 64'(dut.rr_ptr), 64'd2);
    check("ptr_buf", 64'(dut.buf_valid), 64'b1001);
    check("ptr_stall", 64'(req_stall), 64'b0001);
    edge_();
    check("ptr_first", 64'(wb_robid), 64'h43);
    edge_();
    check("ptr_second", 64'(wb_robid), 64'h40);
    check("ptr_end", 64'(dut.rr_ptr), 64'd1);
    edge_();
    edge_();

    // Flush with units 1 and 3 buffered and unit 0 requesting
    set_req(SCALU1, 1'b0, 7'h31, 6'd1, 32'h31);
    set_req(MCALU1, 1'b0, 7'h33, 6'd3, 32'h33);
    edge_();
    clr_req();
    set_req(SCALU0, 1'b0, 7'h30, 6'd0, 32'h30);
    rob_flush = 1'b1;
    #1;
    check("flush_stall", 64'(req_stall), 64'b1010);
    edge_();
    rob_flush = 1'b0;
    clr_req();
    check("flush_wb_valid", 64'(wb_valid), 64'd0);
    check("flush_buf", 64'(dut.buf_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      edge_();
      check("flush_no_wb", 64'(wb_valid), 64'd0);
    end

    // Asynchronous reset in the middle of traffic
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) set_req(i, 1'b0, ROBID_W'(8 + i), RD_W'(i), DATA_W'(k + 1));
      edge_();
    end
    check("pre_reset_stall", 64'(req_stall != 0), 64'd1);
    rst = 1'b0;
    #1;
    check("async_wb_valid", 64'(wb_valid), 64'd0);
    check("async_stall", 64'(req_stall), 64'd0);
    check("async_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    check("async_buf", 64'(dut.buf_valid), 64'd0);
    check("async_wb_result", 64'(wb_result), 64'd0);
    clr_req();
    edge_();
    rst = 1'b1;
    repeat (3) edge_();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
